pipeline_hazard_ctrl: RTL and testbench

// Pipeline sequencer for the 3-stage core (IF/ID, EX, MEM/WB). Owns the stage valid bits and the

---
 rtl/pipeline_hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 3-stage pipeline sequencer: stage enables, valid bits, hazard bubbles, perf counters
module pipeline_hazard_ctrl #(
    parameter int CNT_WIDTH        = 32,
    parameter int REDIRECT_BUBBLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          inst_id,
    input  logic [31:0]          inst_ex,
    input  logic                 redirect_ex,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 pc_en,
    output logic                 id_en,
    output logic                 ex_en,
    output logic                 wb_en,
    output logic                 bubble_ex,
    output logic                 valid_id,
    output logic                 valid_ex,
    output logic                 valid_wb,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    localparam logic [2:0] S_BOOT   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_ISTALL = 3'd2;
    localparam logic [2:0] S_DSTALL = 3'd3;
    localparam logic [2:0] S_REDIR  = 3'd4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [2:0]           state_q, state_d;
    logic                 valid_id_q, valid_id_d;
    logic                 valid_ex_q, valid_ex_d;
    logic                 valid_wb_q, valid_wb_d;
    logic [1:0]           bcnt_q, bcnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic [6:0] op_ex, op_id;
    logic [4:0] rd_ex, rs1_id, rs2_id;
    logic       mem_ex, dstall, lu, redir, rs1_used, rs2_used;
    logic       pc_en_c, id_en_c, ex_en_c, wb_en_c, bubble_c;
    logic       stall_inc, flush_inc;

    assign op_ex  = inst_ex[6:0];
    assign op_id  = inst_id[6:0];
    assign rd_ex  = inst_ex[11:7];
    assign rs1_id = inst_id[19:15];
    assign rs2_id = inst_id[24:20];

    // Unknown opcodes are treated as reading rs1, so a stall is never missed.
    assign rs1_used = !((op_id == OP_LUI) || (op_id == OP_AUIPC) || (op_id == OP_JAL));
    assign rs2_used = (op_id == OP_R) || (op_id == OP_STORE) || (op_id == OP_BRANCH);

    assign mem_ex = valid_ex_q && ((op_ex == OP_LOAD) || (op_ex == OP_STORE));
    assign dstall = mem_ex && !dmem_ready;
    assign redir  = redirect_ex && valid_ex_q;
    assign lu     = valid_ex_q && (op_ex == OP_LOAD) && (rd_ex != 5'd0) && valid_id_q &&
                    ((rs1_used && (rs1_id == rd_ex)) || (rs2_used && (rs2_id == rd_ex)));

    always_comb begin
        state_d    = state_q;
        valid_id_d = valid_id_q;
        valid_ex_d = valid_ex_q;
        valid_wb_d = valid_wb_q;
        bcnt_d     = bcnt_q;
        pc_en_c    = 1'b0;
        id_en_c    = 1'b0;
        ex_en_c    = 1'b0;
        wb_en_c    = 1'b0;
        bubble_c   = 1'b1;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        case (state_q)
            S_BOOT: begin
                if (imem_ready) begin
                    pc_en_c    = 1'b1;
                    id_en_c    = 1'b1;
                    valid_id_d = 1'b1;
                    state_d    = S_RUN;
                end
            end
            // RUN, ISTALL and DSTALL share one priority evaluation; they differ only in entry reason.
            S_RUN, S_ISTALL, S_DSTALL: begin
                if (dstall) begin
                    state_d = S_DSTALL;
                end else begin
                    wb_en_c    = 1'b1;
                    ex_en_c    = 1'b1;
                    valid_wb_d = valid_ex_q;
                    if (redir) begin
                        pc_en_c    = 1'b1;
                        valid_ex_d = 1'b0;
                        valid_id_d = 1'b0;
                        flush_inc  = 1'b1;
                        bcnt_d     = 2'(REDIRECT_BUBBLES - 1);
                        state_d    = (REDIRECT_BUBBLES > 1) ? S_REDIR : S_RUN;
                    end else if (lu) begin
                        valid_ex_d = 1'b0;
                        state_d    = S_RUN;
                    end else if (!imem_ready) begin
                        valid_ex_d = 1'b0;
                        state_d    = S_ISTALL;
                    end else begin
                        pc_en_c    = 1'b1;
                        id_en_c    = 1'b1;
                        bubble_c   = 1'b0;
                        valid_ex_d = valid_id_q;
                        valid_id_d = 1'b1;
                        state_d    = S_RUN;
                    end
                end
                stall_inc = !pc_en_c;
            end
            S_REDIR: begin
                wb_en_c    = 1'b1;
                ex_en_c    = 1'b1;
                pc_en_c    = imem_ready;
                valid_wb_d = valid_ex_q;
                valid_ex_d = 1'b0;
                valid_id_d = 1'b0;
                flush_inc  = 1'b1;
                if (imem_ready) begin
                    if (bcnt_q <= 2'd1) begin
                        bcnt_d  = 2'd0;
                        state_d = S_RUN;
                    end else begin
                        bcnt_d = 2'(bcnt_q - 2'd1);
                    end
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != {CNT_WIDTH{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_inc && (flush_cnt_q != {CNT_WIDTH{1'b1}}))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_BOOT;
            valid_id_q  <= 1'b0;
            valid_ex_q  <= 1'b0;
            valid_wb_q  <= 1'b0;
            bcnt_q      <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_id_q  <= valid_id_d;
            valid_ex_q  <= valid_ex_d;
            valid_wb_q  <= valid_wb_d;
            bcnt_q      <= bcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Enables are combinational, so they are forced idle while reset is held.
    assign pc_en     = pc_en_c && !rst;
    assign id_en     = id_en_c && !rst;
    assign ex_en     = ex_en_c && !rst;
    assign wb_en     = wb_en_c && !rst;
    assign bubble_ex = bubble_c || rst;
    assign valid_id  = valid_id_q;
    assign valid_ex  = valid_ex_q;
    assign valid_wb  = valid_wb_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] LW_X5    = 32'h0001_2283;
    localparam logic [31:0] LW_X0    = 32'h0001_2003;
    localparam logic [31:0] ADD_RS1  = 32'h0012_8333;
    localparam logic [31:0] ADD_RS2  = 32'h0050_8333;
    localparam logic [31:0] ADDI_IMM = 32'h0050_8313;
    localparam logic [31:0] SW_X5    = 32'h0051_2023;
    localparam logic [31:0] BEQ      = 32'h0000_0063;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_id = NOP;
    logic [31:0] inst_ex = NOP;
    logic        redirect_ex = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b1;
    logic        pc_en, id_en, ex_en, wb_en, bubble_ex;
    logic        valid_id, valid_ex, valid_wb;
    logic [3:0]  stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_hazard_ctrl #(.CNT_WIDTH(4), .REDIRECT_BUBBLES(2)) dut (
        .clk(clk), .rst(rst), .inst_id(inst_id), .inst_ex(inst_ex),
        .redirect_ex(redirect_ex), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .id_en(id_en), .ex_en(ex_en), .wb_en(wb_en), .bubble_ex(bubble_ex),
        .valid_id(valid_id), .valid_ex(valid_ex), .valid_wb(valid_wb),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b1;
        redirect_ex = 1'b0;
        inst_id = NOP;
        inst_ex = NOP;
        step();
        rst = 1'b0;
    endtask

    task automatic go_run(input int n);
        do_reset();
        imem_ready = 1'b1;
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_ready = 1'b1;
        step();
        n_checks++;
        if ({pc_en, id_en, ex_en, wb_en, bubble_ex} !== 5'b00001) begin
            n_fail++; $display("FAIL reset_en got %b want 00001", {pc_en, id_en, ex_en, wb_en, bubble_ex});
        end
        n_checks++;
        if ({valid_id, valid_ex, valid_wb} !== 3'b000) begin
            n_fail++; $display("FAIL reset_valid got %b want 000", {valid_id, valid_ex, valid_wb});
        end
        n_checks++;
        if ({stall_cnt, flush_cnt} !== 8'h00) begin
            n_fail++; $display("FAIL reset_cnt got %h want 00", {stall_cnt, flush_cnt});
        end
    endtask

    task automatic test_boot();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if ({pc_en, id_en, ex_en, wb_en, bubble_ex} !== 5'b00001) begin
                n_fail++; $display("FAIL boot_wait c%0d got %b want 00001", c, {pc_en, id_en, ex_en, wb_en, bubble_ex});
            end
            step();
        end
        imem_ready = 1'b1;
        #1;
        n_checks++;
        if ({pc_en, id_en, ex_en, wb_en, bubble_ex} !== 5'b11001) begin
            n_fail++; $display("FAIL boot_go got %b want 11001", {pc_en, id_en, ex_en, wb_en, bubble_ex});
        end
        step();
        n_checks++;
        if ({valid_id, valid_ex, valid_wb, stall_cnt} !== 7'b100_0000) begin
            n_fail++; $display("FAIL boot_valid got %b want 1000000", {valid_id, valid_ex, valid_wb, stall_cnt});
        end
    endtask

    task automatic test_load_use();
        go_run(2);
        inst_ex = LW_X5; inst_id = ADD_RS1;
        #1;
        n_checks++;
        if ({pc_en, id_en, ex_en, wb_en, bubble_ex} !== 5'b00111) begin
            n_fail++; $display("FAIL lu_rs1_en got %b want 00111", {pc_en, id_en, ex_en, wb_en, bubble_ex});
        end
        step();
        n_checks++;
        if ({valid_id, valid_ex, valid_wb, stall_cnt} !== 7'b101_0001) begin
            n_fail++; $display("FAIL lu_rs1_state got %b want 1010001", {valid_id, valid_ex, valid_wb, stall_cnt});
        end
        inst_ex = NOP;
        #1;
        n_checks++;
        if ({pc_en, id_en, ex_en, wb_en, bubble_ex} !== 5'b11110) begin
            n_fail++; $display("FAIL lu_resume got %b want 11110", {pc_en, id_en, ex_en, wb_en, bubble_ex});
        end
        step();
        inst_ex = LW_X5; inst_id = ADD_RS2;
        #1;
        n_checks++;
        if ({pc_en, id_en, ex_en, wb_en, bubble_ex} !== 5'b00111) begin
            n_fail++; $display("FAIL lu_rs2_en got %b want 00111", {pc_en, id_en, ex_en, wb_en, bubble_ex});
        end
        step();
        inst_ex = NOP;
        step();
        inst_ex = LW_X0; inst_id = ADD_RS1;
        #1;
        n_checks++;
        if ({pc_en, id_en, ex_en, wb_en, bubble_ex} !== 5'b11110) begin
            n_fail++; $display("FAIL lu_x0 got %b want 11110", {pc_en, id_en, ex_en, wb_en, bubble_ex});
        end
        step();
        inst_ex = LW_X5; inst_id = ADDI_IMM;
        #1;
        n_checks++;
        if ({pc_en, id_en, ex_en, wb_en, bubble_ex} !== 5'b11110) begin
            n_fail++; $display("FAIL lu_imm got %b want 11110", {pc_en, id_en, ex_en, wb_en, bubble_ex});
        end
        step();
        n_checks++;
        if (stall_cnt !== 4'd2) begin
            n_fail++; $display("FAIL lu_stall_cnt got %0d want 2", stall_cnt);
        end
    endtask

    task automatic test_redirect();
        go_run(2);
        inst_ex = BEQ; redirect_ex = 1'b1;
        #1;
        n_checks++;
        if ({pc_en, id_en, ex_en, wb_en, bubble_ex} !== 5'b10111) begin
            n_fail++; $display("FAIL redir_en got %b want 10111", {pc_en, id_en, ex_en, wb_en, bubble_ex});
        end
        step();
        redirect_ex = 1'b0; inst_ex = NOP;
        n_checks++;
        if ({valid_id, valid_ex, valid_wb, flush_cnt} !== 7'b001_0001) begin
            n_fail++; $display("FAIL redir_c1 got %b want 0010001", {valid_id, valid_ex, valid_wb, flush_cnt});
        end
        #1;
        n_checks++;
        if ({pc_en, id_en, ex_en, wb_en, bubble_ex} !== 5'b10111) begin
            n_fail++; $display("FAIL redir_squash_en got %b want 10111", {pc_en, id_en, ex_en, wb_en, bubble_ex});
        end
        step();
        n_checks++;
        if ({valid_id, valid_ex, valid_wb, flush_cnt} !== 7'b000_0010) begin
            n_fail++; $display("FAIL redir_c2 got %b want 0000010", {valid_id, valid_ex, valid_wb, flush_cnt});
        end
        #1;
        n_checks++;
        if ({pc_en, id_en, ex_en, wb_en, bubble_ex} !== 5'b11110) begin
            n_fail++; $display("FAIL redir_resume got %b want 11110", {pc_en, id_en, ex_en, wb_en, bubble_ex});
        end
        step();
        n_checks++;
        if ({valid_id, flush_cnt} !== 5'b1_0010) begin
            n_fail++; $display("FAIL redir_end got %b want 10010", {valid_id, flush_cnt});
        end
    endtask

    task automatic test_dstall();
        go_run(3);
        inst_ex = SW_X5; dmem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if ({pc_en, id_en, ex_en, wb_en, bubble_ex} !== 5'b00001) begin
                n_fail++; $display("FAIL dstall_en c%0d got %b want 00001", c, {pc_en, id_en, ex_en, wb_en, bubble_ex});
            end
            step();
            n_checks++;
            if ({valid_id, valid_ex, valid_wb} !== 3'b111) begin
                n_fail++; $display("FAIL dstall_valid c%0d got %b want 111", c, {valid_id, valid_ex, valid_wb});
            end
        end
        dmem_ready = 1'b1;
        #1;
        n_checks++;
        if ({pc_en, id_en, ex_en, wb_en, bubble_ex} !== 5'b11110) begin
            n_fail++; $display("FAIL dstall_release got %b want 11110", {pc_en, id_en, ex_en, wb_en, bubble_ex});
        end
        step();
        n_checks++;
        if ({valid_id, valid_ex, valid_wb, stall_cnt} !== 7'b111_0100) begin
            n_fail++; $display("FAIL dstall_end got %b want 1110100", {valid_id, valid_ex, valid_wb, stall_cnt});
        end
    endtask

    task automatic test_dstall_redirect();
        go_run(3);
        inst_ex = SW_X5; dmem_ready = 1'b0; redirect_ex = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if ({pc_en, id_en, ex_en, wb_en, bubble_ex} !== 5'b00001) begin
                n_fail++; $display("FAIL dsr_freeze c%0d got %b want 00001", c, {pc_en, id_en, ex_en, wb_en, bubble_ex});
            end
            step();
        end
        n_checks++;
        if ({valid_id, valid_ex, valid_wb, flush_cnt} !== 7'b111_0000) begin
            n_fail++; $display("FAIL dsr_held got %b want 1110000", {valid_id, valid_ex, valid_wb, flush_cnt});
        end
        dmem_ready = 1'b1;
        #1;
        n_checks++;
        if ({pc_en, id_en, ex_en, wb_en, bubble_ex} !== 5'b10111) begin
            n_fail++; $display("FAIL dsr_apply got %b want 10111", {pc_en, id_en, ex_en, wb_en, bubble_ex});
        end
        step();
        redirect_ex = 1'b0; inst_ex = NOP;
        n_checks++;
        if ({valid_id, valid_ex, valid_wb, flush_cnt, stall_cnt} !== 11'b001_0001_0010) begin
            n_fail++; $display("FAIL dsr_end got %b want 00100010010", {valid_id, valid_ex, valid_wb, flush_cnt, stall_cnt});
        end
    endtask

    task automatic test_saturation();
        go_run(1);
        imem_ready = 1'b0;
        #1;
        n_checks++;
        if ({pc_en, id_en, ex_en, wb_en, bubble_ex} !== 5'b00111) begin
            n_fail++; $display("FAIL istall_en got %b want 00111", {pc_en, id_en, ex_en, wb_en, bubble_ex});
        end
        repeat (20) step();
        n_checks++;
        if (stall_cnt !== 4'hf) begin
            n_fail++; $display("FAIL stall_sat got %0d want 15", stall_cnt);
        end
        imem_ready = 1'b1;
        #1;
        n_checks++;
        if ({pc_en, id_en, ex_en, wb_en, bubble_ex} !== 5'b11110) begin
            n_fail++; $display("FAIL istall_exit got %b want 11110", {pc_en, id_en, ex_en, wb_en, bubble_ex});
        end
        step();
    endtask

    task automatic test_async_reset();
        go_run(2);
        redirect_ex = 1'b1;
        step();
        redirect_ex = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({valid_id, valid_ex, valid_wb, stall_cnt, flush_cnt} !== 11'b0) begin
            n_fail++; $display("FAIL async_rst got %b want 0", {valid_id, valid_ex, valid_wb, stall_cnt, flush_cnt});
        end
        n_checks++;
        if ({pc_en, id_en, ex_en, wb_en, bubble_ex} !== 5'b00001) begin
            n_fail++; $display("FAIL async_rst_en got %b want 00001", {pc_en, id_en, ex_en, wb_en, bubble_ex});
        end
        step();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_boot();
        test_load_use();
        test_redirect();
        test_dstall();
        test_dstall_redirect();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
